// File: rtl/stage_seq_pkg.sv
// rtl/stage_seq_pkg.sv - shared state encoding, stage indices and widths for stage_sequencer
package stage_seq_pkg;

  localparam int NODE_W = 5;
  localparam int IDX_W  = 3;

  localparam int STG_NODES   = 0;
  localparam int STG_ELEMS   = 1;
  localparam int STG_SOURCES = 2;
  localparam int STG_REFNODE = 3;
  localparam int STG_SOLVE   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_ADVANCE,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic [7:0] stage_onehot(input logic [IDX_W-1:0] i);
    return 8'b1 << i;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - 1-bit registered rising-edge detector, async active-low reset
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic armed;

  // armed keeps a level already high at reset release from looking like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= 1'b1;
    end
  end

  assign rise = armed & d & ~d_q;

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - fixed-order stage start/complete sequencer; watchdog under STAGE_WATCHDOG_EN
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES   = STG_SOLVE + 1,
  parameter int NODES_STAGE  = STG_NODES,
  parameter int GROUND_STAGE = STG_REFNODE,
  parameter int WDOG_CYCLES  = 50_000_000
) (
  input  logic                  clk,
  input  logic                  program_resetn,
  input  logic                  go,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  busy,
  output logic                  all_done,
  output logic                  error,
  input  logic [NODE_W-1:0]     numNodes_in,
  input  logic [NODE_W-1:0]     ground_node_in,
  output logic [NODE_W-1:0]     numNodes,
  output logic [NODE_W-1:0]     ground_node
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] NODES_IDX  = IDX_W'(NODES_STAGE);
  localparam logic [IDX_W-1:0] GROUND_IDX = IDX_W'(GROUND_STAGE);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       done_pad;
  logic             go_rise;
  logic             done_rise;

  assign done_pad  = 8'(stage_done);
  assign cur_stage = idx;

  rise_detect u_go_rise (
    .clk  (clk),
    .rst_n(program_resetn),
    .d    (go),
    .rise (go_rise)
  );

  // only the active stage's completion is tracked; other done bits never reach the FSM
  rise_detect u_done_rise (
    .clk  (clk),
    .rst_n(program_resetn),
    .d    (done_pad[idx]),
    .rise (done_rise)
  );

`ifdef STAGE_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge program_resetn) begin
    if (!program_resetn) begin
      state       <= ST_IDLE;
      idx         <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      numNodes    <= '0;
      ground_node <= '0;
`ifdef STAGE_WATCHDOG_EN
      wdog        <= '0;
      error       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go_rise) begin
            state       <= ST_START;
            idx         <= '0;
            stage_start <= NUM_STAGES'(stage_onehot('0));
            busy        <= 1'b1;
            all_done    <= 1'b0;
            numNodes    <= '0;
            ground_node <= '0;
          end
        end
        ST_START: begin
          stage_start <= '0;
          state       <= ST_WAIT;
`ifdef STAGE_WATCHDOG_EN
          wdog        <= '0;
`endif
        end
        ST_WAIT: begin
          if (done_rise) state <= ST_ADVANCE;
`ifdef STAGE_WATCHDOG_EN
          else if (wdog == WDOG_LAST) begin
            state <= ST_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else wdog <= wdog + 1'b1;
`endif
        end
        ST_ADVANCE: begin
          if (idx == NODES_IDX)  numNodes    <= numNodes_in;
          if (idx == GROUND_IDX) ground_node <= ground_node_in;
          if (idx == LAST_IDX) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end else begin
            idx         <= idx + 1'b1;
            stage_start <= NUM_STAGES'(stage_onehot(idx + 1'b1));
            state       <= ST_START;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - self-checking bench for stage_sequencer against a cycle-schedule model
module tb_stage_sequencer;

  localparam int N  = 5;
  localparam int WD = 20;

  logic         clk = 1'b0;
  logic         program_resetn;
  logic         go;
  logic [N-1:0] stage_done;
  logic [N-1:0] stage_start;
  logic [2:0]   cur_stage;
  logic         busy, all_done, error;
  logic [4:0]   numNodes_in, ground_node_in, numNodes, ground_node;

  int n_cmp = 0;
  int n_bad = 0;

  int dly[N];
  int spa[N];
  int spb[N];
  bit sp_en[N];
  bit intf;

  always #5 clk = ~clk;

  stage_sequencer #(
    .NUM_STAGES  (N),
    .NODES_STAGE (0),
    .GROUND_STAGE(3),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk           (clk),
    .program_resetn(program_resetn),
    .go            (go),
    .stage_done    (stage_done),
    .stage_start   (stage_start),
    .cur_stage     (cur_stage),
    .busy          (busy),
    .all_done      (all_done),
    .error         (error),
    .numNodes_in   (numNodes_in),
    .ground_node_in(ground_node_in),
    .numNodes      (numNodes),
    .ground_node   (ground_node)
  );

  function automatic logic [20:0] outs();
    return {stage_start, cur_stage, busy, all_done, error, numNodes, ground_node};
  endfunction

  task automatic set_plain(input int d);
    for (int k = 0; k < N; k++) begin
      dly[k] = d; sp_en[k] = 1'b0; spa[k] = 0; spb[k] = 0;
    end
    intf = 1'b0;
  endtask

  // Stage k starts at s[k]; its done rises at s[k]+dly[k]; the next start follows 2 cycles later.
  task automatic run_seq(input logic [4:0] nn, input logic [4:0] gn, input int abort_stage, input string tag);
    int s[N];
    int fin, ecur, t_nn, t_gn;
    logic [N-1:0] es;
    logic [20:0]  got, want;
    s[0] = 1;
    for (int k = 0; k < N - 1; k++) s[k+1] = s[k] + dly[k] + 2;
    fin  = s[N-1] + dly[N-1] + 2;
    t_nn = s[0] + dly[0] + 2;
    t_gn = s[3] + dly[3] + 2;
    numNodes_in = nn;
    ground_node_in = gn;
    for (int c = 0; c <= fin + 2; c++) begin
      if (c > 0) begin
        es = '0; ecur = 0;
        for (int k = 0; k < N; k++) begin
          if (c == s[k]) es[k] = 1'b1;
          if (c >= s[k]) ecur = k;
        end
        want = {es, 3'(ecur), (c < fin), (c >= fin), 1'b0,
                (c >= t_nn) ? nn : 5'd0, (c >= t_gn) ? gn : 5'd0};
        got = outs();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL %s c=%0d got start=%b cur=%0d busy=%b done=%b err=%b nn=%0d gn=%0d want start=%b cur=%0d busy=%b done=%b err=%b nn=%0d gn=%0d",
                   tag, c, got[20:16], got[15:13], got[12], got[11], got[10], got[9:5], got[4:0],
                   want[20:16], want[15:13], want[12], want[11], want[10], want[9:5], want[4:0]);
        end
      end
      if (abort_stage >= 0 && c == s[abort_stage] + 2) begin
        program_resetn = 1'b0;
        go = 1'b0;
        stage_done = '0;
        @(negedge clk);
        got = outs();
        n_cmp++;
        if (got !== 21'd0) begin
          n_bad++;
          $display("FAIL %s_reset got busy=%b cur=%0d nn=%0d outs=%h want all zero", tag, got[12], got[15:13], got[9:5], got);
        end
        program_resetn = 1'b1;
        @(negedge clk);
        return;
      end
      go = (c == 0) || (intf && c == s[1] + 2);
      for (int k = 0; k < N; k++)
        stage_done[k] = (sp_en[k] && c >= s[k] + spa[k] && c <= s[k] + spb[k]) || (c >= s[k] + dly[k]);
      if (intf && c == s[1] + 2) stage_done[3] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [20:0] got;
    program_resetn = 1'b0;
    go = 1'b1;
    repeat (3) @(negedge clk);
    got = outs();
    n_cmp++;
    if (got !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_hold got %h want 0", got);
    end
    program_resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = outs();
      n_cmp++;
      if (got !== 21'd0) begin
        n_bad++;
        $display("FAIL reset_go_held cycle %0d got %h want 0", i, got);
      end
    end
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    set_plain(5);
    run_seq(5'd6, 5'd2, -1, "sequence");
    n_cmp++;
    if ({numNodes, ground_node, all_done} !== {5'd6, 5'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL sequence_final got nn=%0d gn=%0d all_done=%b want nn=6 gn=2 all_done=1", numNodes, ground_node, all_done);
    end
  endtask

  task automatic test_stale_and_interference();
    set_plain(3);
    sp_en[0] = 1'b1; spa[0] = -1; spb[0] = 3; dly[0] = 8;
    sp_en[1] = 1'b1; spa[1] = 0;  spb[1] = 3; dly[1] = 7;
    intf = 1'b1;
    run_seq(5'd17, 5'd9, -1, "stale_intf");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        sp_en[k] = 1'($urandom_range(0, 1));
        spa[k] = int'($urandom_range(0, 1)) - 1;
        spb[k] = spa[k] + int'($urandom_range(0, 2));
        dly[k] = sp_en[k] ? spb[k] + 3 + int'($urandom_range(0, 3)) : 2 + int'($urandom_range(0, 7));
      end
      intf = 1'($urandom_range(0, 1));
      if (intf && dly[1] < 3) dly[1] = 3;
      run_seq(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), -1, "back_to_back");
    end
  endtask

  task automatic test_reset_mid();
    set_plain(4);
    run_seq(5'd6, 5'd2, 2, "reset_mid");
  endtask

  task automatic test_watchdog();
    logic [4:0] got, want;
    stage_done = '0;
    go = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 40; c++) begin
`ifdef STAGE_WATCHDOG_EN
      want = {(c < WD + 2), (c >= WD + 2), 3'd0};
`else
      want = {1'b1, 1'b0, 3'd0};
`endif
      got = {busy, error, cur_stage};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL watchdog c=%0d got busy=%b err=%b cur=%0d want busy=%b err=%b cur=%0d",
                 c, got[4], got[3], got[2:0], want[4], want[3], want[2:0]);
      end
      go = (c == 25);
      @(negedge clk);
    end
    program_resetn = 1'b0;
    go = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({error, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL watchdog_reset got err=%b busy=%b want 0 0", error, busy);
    end
    program_resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    program_resetn = 1'b0;
    go = 1'b0;
    stage_done = '0;
    numNodes_in = '0;
    ground_node_in = '0;
    set_plain(2);
    test_reset();
    test_sequence();
    test_stale_and_interference();
    test_back_to_back();
    test_reset_mid();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Top-level stage controller for the circuit-analysis flow. It steps through the stage controllers (node count entry, element entry, …, reference-node choice, solve) in fixed order. For each stage it issues a one-cycle `start_process` pulse and waits for that stage's `end_process`. At specific stage boundaries it latches the shared results `numNodes` and `ground_node` and passes them on to later stages. It sits directly under the board top, between the FPGA keys and the per-stage `*_main` blocks.

## Interface
Parameters:
- `NUM_STAGES`, 5: number of sequenced stages, 2..8.
- `NODES_STAGE`, 0: index of the stage whose completion supplies `numNodes`.
- `GROUND_STAGE`, 3: index of the stage whose completion supplies `ground_node`.
- `WDOG_CYCLES`, 50_000_000: watchdog limit per stage, in `clk` cycles (used only with `STAGE_WATCHDOG_EN`).

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `program_resetn`, in, 1: reset, asynchronous and active-low.
- `go`, in, 1: level from `~KEY[3]`; edge-detected internally.
- `stage_done`, in, `NUM_STAGES`: `end_process` of each stage (level).
- `stage_start`, out, `NUM_STAGES`: one-hot `start_process` pulses.
- `cur_stage`, out, 3: index of the active stage.
- `busy`, out, 1: high while any stage is running.
- `all_done`, out, 1: high once the last stage has completed.
- `error`, out, 1: watchdog expired.
- `numNodes_in`, in, 5: `numNodes` as driven by stage `NODES_STAGE`.
- `ground_node_in`, in, 5: `ground_node` as driven by stage `GROUND_STAGE`.
- `numNodes`, out, 5: latched node count, broadcast to all stages.
- `ground_node`, out, 5: latched reference node.

## Operation
- States:
  - `IDLE`: waiting for `go`.
  - `START`: pulse the current stage.
  - `WAIT`: wait for the current stage to complete.
  - `ADVANCE`: capture results and step to the next stage.
  - `DONE`: all stages complete.
  - `ERROR`: watchdog expired (only with `STAGE_WATCHDOG_EN`).
- Transitions:
  - `IDLE` → `START`: on a rising edge of `go`. Sets `idx`=0 and clears `numNodes`/`ground_node`.
  - `START` → `WAIT`: unconditional. `stage_start[idx]`=1 for exactly this cycle.
  - `WAIT` → `ADVANCE`: on a rising edge of `stage_done[idx]`. The previous value is registered in `WAIT`, so a `stage_done` that is already high on entry does not count.
  - `ADVANCE`:
    - If `idx`==`NODES_STAGE`, latch `numNodes_in`.
    - If `idx`==`GROUND_STAGE`, latch `ground_node_in`.
    - If `idx`==`NUM_STAGES`-1, go to `DONE`; otherwise `idx`+1 and go to `START`.
  - `DONE` → `START`: on a rising edge of `go`. Restarts from stage 0 and clears the latched values.
- `stage_done` bits other than `idx` are ignored in every state.
- `go` edges in `START`, `WAIT` and `ADVANCE` are ignored. Stages consume `go` themselves.
- Outputs:
  - `cur_stage` = `idx`, zero-extended.
  - `busy` = 1 in `START`, `WAIT` and `ADVANCE`.
  - `all_done` = 1 in `DONE`.
- Arithmetic: `idx` is 3 bits. It never exceeds `NUM_STAGES`-1, so it does not wrap.

## Timing
- Reset values:
  - State `IDLE`, `idx`=0.
  - `stage_start`=0, `cur_stage`=0, `busy`=0, `all_done`=0, `error`=0.
  - `numNodes`=0, `ground_node`=0.
  - Edge-detect registers are 0.
- Reset mid-operation: returns immediately to `IDLE` and all outputs take their reset values. A `go` held high through reset release does not produce an edge.
- Latencies:
  - `go` rising edge sampled at cycle n → `stage_start[0]` high in cycle n+1.
  - Completion edge sampled at cycle m → latched values valid from m+2, and `stage_start[idx+1]` high in cycle m+2.
  - After the last stage completes, `all_done` is high from m+2.
- A stage completes at the earliest 2 cycles after its start pulse. A `stage_done` edge in the `START` cycle is not seen.

## Configuration
- `STAGE_WATCHDOG_EN` defined:
  - A cycle counter (up to `WDOG_CYCLES`) is cleared on entry to `WAIT` and increments each `WAIT` cycle.
  - On reaching `WDOG_CYCLES` without completion, the state goes to `ERROR` with `error`=1 and `busy`=0.
  - `ERROR` exits only via `program_resetn`.
- `STAGE_WATCHDOG_EN` undefined: there is no counter and no `ERROR` state, `error` is tied to 0, and `WAIT` waits indefinitely.

## Structure
- Shared package `stage_seq_pkg`:
  - State encoding constants.
  - Stage index constants (`STG_NODES`, `STG_ELEMS`, `STG_REFNODE`, …).
  - Node-field width 5.
- One sub-module, `rise_detect`: a 1-bit registered edge detector with asynchronous active-low reset. It is used for `go` and for the selected `stage_done` bit.

## Test plan
- Reset with `go`=1 held, then release → no `stage_start` activity; all outputs 0.
- `go` edge; each stage raises `done` 5 cycles after its start, with `numNodes_in`=6 and `ground_node_in`=2 → `stage_start` pulses 0..4 in order, each exactly 1 cycle wide, 2 cycles after the previous completion; finishes with `numNodes`=6, `ground_node`=2, `all_done`=1.
- Hold `stage_done[0]` high from before the start pulse, then drop it and raise it again → only the new rising edge advances the sequence.
- While stage 1 is running, pulse `stage_done[3]` and `go` → no state change, `cur_stage` stays 1.
- Assert `program_resetn`=0 during stage 2 → next cycle `busy`=0, `cur_stage`=0, `numNodes`=0.
- With `STAGE_WATCHDOG_EN` and `WDOG_CYCLES`=20, never complete stage 0 → `error`=1 after 20 `WAIT` cycles; a `go` edge has no effect; reset clears `error`.
